// File: rtl/pn_readout_if.sv
// Job request, PN-memory read port and output word stream of pn_readout.
// slave is the readout block's view; master is the job/memory/consumer side.
interface pn_readout_if #(parameter int ADDR_WIDTH = 5);
  logic                  start;
  logic [15:0]           id;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_dout;
  logic [31:0]           dout;
  logic                  dout_valid;
  logic                  dout_rd;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, id, mem_dout, dout_rd,
    output mem_rd_en, mem_addr, dout, dout_valid, busy, done
  );

  modport master (
    output start, id, mem_dout, dout_rd,
    input  mem_rd_en, mem_addr, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/pn_readout.sv
// Reads WORD_COUNT PN words per job into a 2-entry output buffer and streams them.
// Define PN_READOUT_HEADER_EN to prepend the header word {16'h0000, id} to each job.
module pn_readout #(
  parameter     BASE_ADDR  = 5'd0,
  parameter int WORD_COUNT = 6,
  parameter int ADDR_WIDTH = 5
) (
  input logic         CLK,
  input logic         reset,
  pn_readout_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [5:0]            issued_q, issued_d;
  logic [5:0]            xfer_q, xfer_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  logic [31:0]           buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [31:0]           push_data;
  logic                  pop, room, accept, issue, hdr_slot;

`ifdef PN_READOUT_HEADER_EN
  localparam int HDR_SLOTS = 1;

  logic [15:0] id_q, id_d;
  logic        hdr_fl_q, hdr_fl_d;

  // Slot 0 of a job is the header; it travels the read pipeline without touching memory.
  assign hdr_slot  = (issued_q == 6'd0);
  assign push_data = hdr_fl_q ? {16'h0000, id_q} : bus.mem_dout;

  always_comb begin
    id_d     = accept ? bus.id : id_q;
    hdr_fl_d = issue && hdr_slot;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      id_q     <= '0;
      hdr_fl_q <= 1'b0;
    end else begin
      id_q     <= id_d;
      hdr_fl_q <= hdr_fl_d;
    end
  end
`else
  localparam int HDR_SLOTS = 0;

  assign hdr_slot  = 1'b0;
  assign push_data = bus.mem_dout;
`endif

  localparam int         NSLOT = WORD_COUNT + HDR_SLOTS;
  localparam logic [5:0] LAST  = 6'(NSLOT - 1);

  always_comb begin
    pop    = (cnt_q != 2'd0) && bus.dout_rd;
    room   = ({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    accept = (state_q == IDLE) && bus.start && !reset;
    // The accepting cycle already issues slot 0 so the first word is registered
    // on dout two cycles after start.
    issue  = room && (accept || ((state_q == READ) && !reset));

    state_d    = state_q;
    issued_d   = issued_q;
    xfer_d     = xfer_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    inflight_d = issue;

    if (issue) begin
      issued_d = issued_q + 6'd1;
      if (!hdr_slot) addr_d = addr_q + ADDR_WIDTH'(1);
    end
    if (pop) xfer_d = xfer_q + 6'd1;

    case (state_q)
      IDLE:    if (accept) state_d = (issued_q == LAST) ? DRAIN : READ;
      READ:    if (issue && (issued_q == LAST)) state_d = DRAIN;
      DRAIN: begin
        if (pop && (xfer_q == LAST)) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          issued_d = '0;
          xfer_d   = '0;
          addr_d   = BASE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop shifts the head out first; returning data then lands in the first free entry.
    buf0_d = pop ? buf1_q : buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q - {1'b0, pop};
    if (inflight_q) begin
      if (cnt_d == 2'd0) buf0_d = push_data;
      else               buf1_d = push_data;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      xfer_q     <= '0;
      addr_q     <= BASE;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      xfer_q     <= xfer_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_rd_en  = issue && !hdr_slot;
  assign bus.mem_addr   = addr_q;
  assign bus.dout       = buf0_q;
  assign bus.dout_valid = (cnt_q != 2'd0);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_pn_readout.sv
// Self-checking bench for pn_readout: directed vector table, corner sequences and
// randomized jobs scored against a transaction-level model of the readout.
module tb_pn_readout;
  localparam int            AW   = 5;
  localparam int            WC   = 6;
  localparam logic [AW-1:0] BASE = 5'd0;
`ifdef PN_READOUT_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif
  localparam int NW = WC + (HDR ? 1 : 0);

  logic CLK = 1'b0;
  logic reset;

  pn_readout_if #(.ADDR_WIDTH(AW)) bus ();

  pn_readout #(.BASE_ADDR(BASE), .WORD_COUNT(WC), .ADDR_WIDTH(AW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] pn [0:(1<<AW)-1];

  // Synchronous PN memory: data one cycle after the strobe, noise otherwise.
  always @(posedge CLK) bus.mem_dout <= bus.mem_rd_en ? pn[bus.mem_addr] : $urandom;

  typedef struct {
    logic        start;
    logic        rd;
    logic        e_rden;
    logic        e_valid;
    logic [31:0] e_dout;
    logic        chk_dout;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl [0:10];
  vec_t cur;
  logic tbl_en = 1'b0;
  logic tmo    = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: a job is a list of expected words plus occupancy accounting.
  logic [31:0]   exp_q [$];
  logic          active    = 1'b0;
  logic          done_pend = 1'b0;
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_dout = '0;
  int            mreads = 0, xfers = 0, outst = 0;
  logic [AW-1:0] next_addr = BASE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic          xfer, acc, exp_rd, was_active;
    logic [31:0]   w;
    logic [AW-1:0] a;
    xfer   = bus.dout_valid && bus.dout_rd;
    acc    = !active && bus.start && !reset;
    exp_rd = !reset && ((acc && !HDR) ||
             (active && (mreads < WC) && ((outst - (xfer ? 1 : 0)) < 2)));

    chk("busy", 32'(bus.busy), 32'(active));
    chk("done", 32'(bus.done), 32'(done_pend));
    chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(exp_rd));
    if (exp_rd) chk("mem_addr", 32'(bus.mem_addr), 32'(next_addr));
    if (!active) begin
      chk("idle_valid", 32'(bus.dout_valid), 32'd0);
      chk("idle_addr", 32'(bus.mem_addr), 32'(BASE));
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(bus.dout_valid), 32'd1);
      chk("stall_dout", bus.dout, prev_dout);
    end
    if (xfer) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(bus.dout_valid), 32'd0);
      else begin
        w = exp_q.pop_front();
        chk("dout_word", bus.dout, w);
      end
    end
    if (tbl_en) begin
      chk("tbl_rden", 32'(bus.mem_rd_en), 32'(cur.e_rden));
      chk("tbl_valid", 32'(bus.dout_valid), 32'(cur.e_valid));
      chk("tbl_busy", 32'(bus.busy), 32'(cur.e_busy));
      chk("tbl_done", 32'(bus.done), 32'(cur.e_done));
      if (cur.chk_dout) chk("tbl_dout", bus.dout, cur.e_dout);
    end
    if (tmo) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_bound: job did not finish, busy=%0d", bus.busy);
    end

    if (reset) begin
      active = 1'b0; done_pend = 1'b0; prev_stall = 1'b0;
      exp_q.delete();
      mreads = 0; xfers = 0; outst = 0; next_addr = BASE;
    end else begin
      prev_stall = bus.dout_valid && !bus.dout_rd;
      prev_dout  = bus.dout;
      was_active = active;
      done_pend  = 1'b0;
      if (acc) begin
        active = 1'b1; mreads = 0; xfers = 0; outst = 0; next_addr = BASE;
        if (HDR) begin
          exp_q.push_back({16'h0000, bus.id});
          outst = 1;
        end
        for (int i = 0; i < WC; i++) begin
          a = BASE + AW'(i);
          exp_q.push_back(pn[a]);
        end
      end
      if (exp_rd) begin
        mreads++; outst++; next_addr = next_addr + AW'(1);
      end
      if (xfer) begin
        outst--; xfers++;
      end
      if (was_active && (xfers == NW)) begin
        active = 1'b0; done_pend = 1'b1; next_addr = BASE;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rd_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      2:       return cyc >= 10;
      3:       return $urandom_range(0, 1) == 1;
      default: return $urandom_range(0, 99) < 80;
    endcase
  endfunction

  task automatic run_job(input int mode, input bit spam, input int rst_pct);
    int cyc;
    bus.id      = 16'($urandom);
    bus.start   = 1'b1;
    bus.dout_rd = rd_for(mode, 0);
    tick();
    bus.start = 1'b0;
    for (cyc = 1; cyc < 400; cyc++) begin
      bus.dout_rd = rd_for(mode, cyc);
      bus.start   = spam && bus.busy && ($urandom_range(0, 1) == 1);
      reset       = (rst_pct > 0) && ($urandom_range(0, 99) < rst_pct);
      tick();
      if (reset) begin
        reset = 1'b0; bus.start = 1'b0;
        return;
      end
      if (bus.done) break;
    end
    bus.start = 1'b0;
    if (cyc >= 400) begin
      tmo = 1'b1;
      tick();
      tmo = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) pn[i] = $urandom;
    for (int i = 0; i < 6; i++) pn[i] = 32'h11111111 * (i + 1);

`ifdef PN_READOUT_HEADER_EN
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000A5C3, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h66666666, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
`else
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h66666666, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
`endif

    reset = 1'b1; bus.start = 1'b0; bus.id = 16'hA5C3; bus.dout_rd = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Nominal job, cycle by cycle.
    for (int r = 0; r <= 10; r++) begin
      bus.start   = tbl[r].start;
      bus.dout_rd = tbl[r].rd;
      cur         = tbl[r];
      tbl_en      = 1'b1;
      tick();
    end
    tbl_en = 1'b0;
    repeat (2) tick();

    run_job(2, 1'b0, 0);   // consumer stalled for 10 cycles
    run_job(1, 1'b0, 0);   // alternating accept
    run_job(3, 1'b1, 0);   // start re-asserted mid-job

    // Reset with one word buffered and one in flight, then a fresh job.
    bus.start = 1'b1; bus.dout_rd = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    run_job(0, 1'b0, 0);

    // Start coinciding with reset must leave the block idle.
    reset = 1'b1; bus.start = 1'b1;
    tick();
    reset = 1'b0; bus.start = 1'b0;
    repeat (2) tick();

    for (int j = 0; j < 40; j++) run_job($urandom_range(0, 4), 1'($urandom_range(0, 1)), 3);
    for (int j = 0; j < 10; j++) begin
      run_job(4, 1'b0, 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    bus.dout_rd = 1'b1;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
